mem_line_ctrl: RTL and testbench
================================

MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles each memory strobe is held before completion (legal 1..15).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  line request offered.
REQ-005 SHALL have port req_ready  out  1  controller accepts request.
REQ-006 SHALL have port req_write  in  1  1 = line write, 0 = line read.
REQ-007 SHALL have port req_addr  in  9  starting word address.
REQ-008 SHALL have port req_wdata  in  512  write line; word i in bits [i*32 +: 32].
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  requester consumes response.
REQ-011 SHALL have port rsp_write  out  1  echo of accepted req_write.
REQ-012 SHALL have port rsp_rdata  out  512  read line; all-zero for write responses.
REQ-013 SHALL have port mem_address  out  9  to memory word address.
REQ-014 SHALL have ports mem_read  out  1 and mem_write  out  1: memory strobes, never both high.
REQ-015 SHALL have port mem_din  out  512  write line to memory.
REQ-016 SHALL have port mem_dout  in  512  read line from memory (16 words from mem_address, wrapping modulo 512).
REQ-017 SHALL have ports rd_count  out  16 and wr_count  out  16: completed-transfer counters.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-019 SHALL, in IDLE, drive req_ready=1; all other states req_ready=0.
REQ-020 SHALL, on req_valid&&req_ready, register addr, write flag and wdata, clear latency counter, and enter ACCESS next cycle.
REQ-021 SHALL, in ACCESS, drive mem_address/mem_din from registers and assert exactly one strobe, selected by the registered write flag, for exactly MEM_LAT consecutive cycles.
REQ-022 SHALL, on the last ACCESS cycle of a read, capture mem_dout into rsp_rdata; on a write, set rsp_rdata to zero.
REQ-023 SHALL enter RESP after the last ACCESS cycle and hold rsp_valid=1, stable rsp_rdata and rsp_write until rsp_ready=1.
REQ-024 SHALL return to IDLE the cycle after rsp_valid&&rsp_ready; rsp_ready while rsp_valid=0 is ignored.
REQ-025 SHALL yield accept-to-rsp_valid latency of MEM_LAT+1 cycles and minimum request spacing of MEM_LAT+2 cycles.
REQ-026 SHALL drive mem_read=mem_write=0 and mem_din=0 outside ACCESS; mem_address holds last registered address.
REQ-027 SHALL pass req_addr unmodified; addresses 497..511 rely on memory modulo-512 wrap, with no controller splitting.
REQ-028 SHALL increment rd_count or wr_count by 1 on the response handshake, saturating at 16'hFFFF.
REQ-029 SHALL ignore req_valid changes and req_* data outside IDLE.

Reset
REQ-030 SHALL, while rst_n=0, force IDLE, req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_din=0, counters=0, immediately and asynchronously.
REQ-031 SHALL abandon any in-flight transfer on reset with no response and no count; req_ready rises the first clock edge after rst_n deasserts.

Structure
REQ-032 SHALL take ADDR_W=9, WORD_W=32, WORDS=16, LINE_W=512 and the state enum from shared package mem_line_pkg.
REQ-033 SHALL place the MEM_LAT strobe counter in sub-module mem_line_timer (start, done pulse on last cycle).

Verification
REQ-034 SHALL verify: read addr 0, MEM_LAT=2, rsp_ready=1 -> mem_read high 2 cycles, rsp_rdata words 0..15 = FFFFFFF0..FFFFFFFF, rsp_valid 3 cycles after accept, rd_count=1.
REQ-035 SHALL verify: read addr 55 -> all 16 words FFFFFFFF; read addr 71 -> all 16 words 00000001.
REQ-036 SHALL verify: write addr 200 with word i = 0x1000+i, then read addr 200 -> rsp_rdata word i = 0x1000+i, rsp_rdata=0 on write response, wr_count=1, rd_count=1.
REQ-037 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no strobes, counters unchanged until handshake.
REQ-038 SHALL verify: rst_n pulsed low during ACCESS -> strobes and rsp_valid drop without a clock, counters 0, new read at addr 87 afterwards returns sixteen 7FFFFFFF.
REQ-039 SHALL verify: read addr 510 -> mem_address=510, rsp_rdata equals memory words 510,511,0..13.

Source files
------------

// File: rtl/mem_line_pkg.sv
// mem_line_pkg
//   Shared widths, the controller state encoding and a saturating counter
//   helper for the line memory controller (mem_line_ctrl) and its timer.
//   No ports; imported by mem_line_ctrl and mem_line_timer.
package mem_line_pkg;

    localparam int ADDR_W = 9;
    localparam int WORD_W = 32;
    localparam int WORDS  = 16;
    localparam int LINE_W = WORD_W * WORDS;
    localparam int CNT_W  = 16;
    localparam int LAT_W  = 4;   // wide enough for MEM_LAT up to 15

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } line_state_t;

    // Transfer counters stick at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_line_timer.sv
// mem_line_timer
//   Counts the memory strobe duration. A start pulse arms the timer; the
//   following MEM_LAT cycles are the strobe window and done pulses high
//   during the last of them.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset
//     start  in   arm the timer (restarts the count from zero)
//     done   out  high during the final cycle of the window
module mem_line_timer
    import mem_line_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam logic [LAT_W-1:0] LAST = LAT_W'(MEM_LAT - 1);

    logic [LAT_W-1:0] cnt_reg;
    logic             active_reg;

    assign done = active_reg && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (done) begin
                active_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
//   Turns one line request (16 x 32-bit words) into a single memory access
//   whose strobe is held for MEM_LAT cycles, then presents a response and
//   waits for the requester to take it. One transfer in flight at a time.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid/req_ready        request handshake
//     req_write, req_addr        operation and starting word address
//     req_wdata                  write line, word i in bits [i*32 +: 32]
//     rsp_valid/rsp_ready        response handshake
//     rsp_write, rsp_rdata       echoed operation, read line (zero on writes)
//     mem_address, mem_read,
//     mem_write, mem_din         memory side strobes and write line
//     mem_dout                   memory read line (wraps modulo 512 in memory)
//     rd_count, wr_count         saturating completed-transfer counters
module mem_line_ctrl
    import mem_line_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_din,
    input  logic [LINE_W-1:0] mem_dout,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    line_state_t       state_reg, state_next;
    logic              ready_en_reg;     // keeps req_ready low until the first edge after reset
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic [LINE_W-1:0] rdata_reg, rdata_next;
    logic              rsp_write_reg;
    logic [CNT_W-1:0]  rd_count_reg, wr_count_reg;

    logic accept;
    logic rsp_hs;
    logic timer_done;
    logic in_access;

    assign accept = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Strobe window length is owned by the timer; ACCESS ends on its done pulse.
    mem_line_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .done  (timer_done)
    );

    // Next state and handshake/strobe outputs. Outputs decode straight from
    // registers, so an asynchronous reset drops them without a clock.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        in_access  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = ready_en_reg;
                if (req_valid && ready_en_reg) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                in_access = 1'b1;
                mem_read  = !write_reg;
                mem_write = write_reg;
                if (timer_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-word datapath: read capture zeroes on writes, write line is only
    // presented to memory while the strobe window is open.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            assign rdata_next[gi*WORD_W +: WORD_W] =
                write_reg ? '0 : mem_dout[gi*WORD_W +: WORD_W];
            assign mem_din[gi*WORD_W +: WORD_W] =
                in_access ? wdata_reg[gi*WORD_W +: WORD_W] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_en_reg  <= 1'b0;
            addr_reg      <= '0;
            write_reg     <= 1'b0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            rsp_write_reg <= 1'b0;
            rd_count_reg  <= '0;
            wr_count_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
            if (accept) begin
                addr_reg  <= req_addr;
                write_reg <= req_write;
                wdata_reg <= req_wdata;
            end
            // Last strobe cycle: memory data is valid now, freeze it for RESP.
            if (in_access && timer_done) begin
                rdata_reg     <= rdata_next;
                rsp_write_reg <= write_reg;
            end
            if (rsp_hs) begin
                if (rsp_write_reg) begin
                    wr_count_reg <= sat_inc(wr_count_reg);
                end else begin
                    rd_count_reg <= sat_inc(rd_count_reg);
                end
            end
        end
    end

    assign mem_address = addr_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_write   = rsp_write_reg;
    assign rd_count    = rd_count_reg;
    assign wr_count    = wr_count_reg;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl
//   Directed bench for mem_line_ctrl (MEM_LAT=2) with a 512-word memory model
//   that returns 16 words from mem_address, wrapping modulo 512.
module tb_mem_line_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [8:0]   req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_write;
    logic [511:0] rsp_rdata;
    logic [8:0]   mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [511:0] mem_din;
    logic [511:0] mem_dout;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int checks = 0;
    int errors = 0;

    mem_line_ctrl #(.MEM_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [0:511];
    logic        mem_loaded = 1'b0;

    function automatic logic [31:0] init_word(input int a);
        if (a < 16)                 return 32'hFFFF_FFF0 + 32'(a);
        else if (a >= 55 && a < 71) return 32'hFFFF_FFFF;
        else if (a >= 71 && a < 87) return 32'h0000_0001;
        else if (a >= 87 && a < 103) return 32'h7FFF_FFFF;
        else                        return 32'hA500_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < 512; a++) mem_arr[a] <= init_word(a);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            for (int i = 0; i < 16; i++)
                mem_arr[9'(mem_address + 9'(i))] <= mem_din[i*32 +: 32];
        end
    end

    always_comb begin
        mem_dout = '0;
        for (int i = 0; i < 16; i++)
            mem_dout[i*32 +: 32] = mem_arr[9'(mem_address + 9'(i))];
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer a request from a negedge; returns #1 after the accepting edge,
    // then scrambles req_* so later changes must be ignored.
    task automatic send_req(input logic w, input logic [8:0] a, input logic [511:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            errors++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    endtask

    // Sample each negedge after accept until rsp_valid; tally strobes and
    // cycles where address/data/strobe pairing is wrong.
    task automatic wait_rsp(input logic [8:0] exp_addr, input logic is_wr, input logic [511:0] exp_din,
                            output int lat, output int rd_cyc, output int wr_cyc, output int bad_cyc);
        lat = 0; rd_cyc = 0; wr_cyc = 0; bad_cyc = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read && mem_write) bad_cyc++;
            if ((mem_read || mem_write) && mem_address !== exp_addr) bad_cyc++;
            if (mem_write && is_wr && mem_din !== exp_din) bad_cyc++;
            if (rsp_valid) break;
        end
        checks++;
        if (!rsp_valid) begin
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            errors++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_write, mem_read, mem_write} !== 5'b0 ||
            rsp_rdata !== '0 || mem_address !== '0 || mem_din !== '0 ||
            rd_count !== '0 || wr_count !== '0) begin
            $display("FAIL reset_outputs: rdy=%b vld=%b rw=%b rd=%b wr=%b addr=%h rc=%h wc=%h required all 0",
                     req_ready, rsp_valid, rsp_write, mem_read, mem_write, mem_address, rd_count, wr_count);
            errors++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            $display("FAIL ready_before_edge: req_ready=%b required 0", req_ready);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_after_edge: req_ready=%b required 1", req_ready);
            errors++;
        end
        $display("test_reset done");
    endtask

    task automatic test_read_basic();
        int lat, rc, wc, bad;
        logic [511:0] exp;
        for (int i = 0; i < 16; i++) exp[i*32 +: 32] = 32'hFFFF_FFF0 + 32'(i);
        rsp_ready = 1'b1;
        send_req(1'b0, 9'd0, '0);
        wait_rsp(9'd0, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (lat != 3 || rc != 2 || wc != 0 || bad != 0) begin
            $display("FAIL read0_timing: lat=%0d rd=%0d wr=%0d bad=%0d required 3 2 0 0", lat, rc, wc, bad);
            errors++;
        end
        checks++;
        if (rsp_rdata !== exp || rsp_write !== 1'b0) begin
            $display("FAIL read0_data: got %h w=%b required %h w=0", rsp_rdata, rsp_write, exp);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd1 || wr_count !== 16'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_din !== '0) begin
            $display("FAIL read0_done: rc=%0d wc=%0d vld=%b rdy=%b required 1 0 0 1", rd_count, wr_count, rsp_valid, req_ready);
            errors++;
        end
        $display("read addr 0: lat=%0d rd_count=%0d", lat, rd_count);
    endtask

    task automatic test_read_patterns();
        int lat, rc, wc, bad;
        send_req(1'b0, 9'd55, '0);
        wait_rsp(9'd55, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (rsp_rdata !== {16{32'hFFFF_FFFF}} || bad != 0) begin
            $display("FAIL read55_data: got %h bad=%0d required all FFFFFFFF", rsp_rdata, bad);
            errors++;
        end
        send_req(1'b0, 9'd71, '0);
        wait_rsp(9'd71, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (rsp_rdata !== {16{32'h0000_0001}} || bad != 0) begin
            $display("FAIL read71_data: got %h bad=%0d required all 00000001", rsp_rdata, bad);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd3) begin
            $display("FAIL patterns_count: rd_count=%0d required 3", rd_count);
            errors++;
        end
        $display("read addr 55/71: rd_count=%0d", rd_count);
    endtask

    task automatic test_write_read();
        int lat, rc, wc, bad;
        logic [511:0] line;
        for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'h1000 + 32'(i);
        do_reset();
        rsp_ready = 1'b1;
        send_req(1'b1, 9'd200, line);
        wait_rsp(9'd200, 1'b1, line, lat, rc, wc, bad);
        checks++;
        if (lat != 3 || rc != 0 || wc != 2 || bad != 0) begin
            $display("FAIL write_timing: lat=%0d rd=%0d wr=%0d bad=%0d required 3 0 2 0", lat, rc, wc, bad);
            errors++;
        end
        checks++;
        if (rsp_rdata !== '0 || rsp_write !== 1'b1) begin
            $display("FAIL write_rsp: rdata=%h w=%b required 0 w=1", rsp_rdata, rsp_write);
            errors++;
        end
        send_req(1'b0, 9'd200, '0);
        wait_rsp(9'd200, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (rsp_rdata !== line || rsp_write !== 1'b0) begin
            $display("FAIL readback_data: got %h w=%b required %h w=0", rsp_rdata, rsp_write, line);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
            $display("FAIL write_read_counts: wc=%0d rc=%0d required 1 1", wr_count, rd_count);
            errors++;
        end
        $display("write/read addr 200: wr_count=%0d rd_count=%0d", wr_count, rd_count);
    endtask

    task automatic test_backpressure();
        int lat, rc, wc, bad;
        int unstable;
        rsp_ready = 1'b0;
        send_req(1'b0, 9'd55, '0);
        wait_rsp(9'd55, 1'b0, '0, lat, rc, wc, bad);
        unstable = 0;
        for (int c = 0; c < 5; c++) begin
            req_addr = 9'(c * 37);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== {16{32'hFFFF_FFFF}} || req_ready !== 1'b0 ||
                mem_read !== 1'b0 || mem_write !== 1'b0 || rd_count !== 16'd1 || wr_count !== 16'd1)
                unstable++;
        end
        checks++;
        if (unstable != 0) begin
            $display("FAIL hold_stable: unstable_cycles=%0d required 0 (vld=%b rc=%0d)", unstable, rsp_valid, rd_count);
            errors++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd2 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL hold_release: rc=%0d vld=%b rdy=%b required 2 0 1", rd_count, rsp_valid, req_ready);
            errors++;
        end
        $display("backpressure: rd_count=%0d", rd_count);
    endtask

    task automatic test_async_reset();
        int lat, rc, wc, bad;
        send_req(1'b0, 9'd71, '0);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            $display("FAIL access_before_reset: mem_read=%b required 1", mem_read);
            errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 ||
            rd_count !== '0 || wr_count !== '0 || mem_address !== '0) begin
            $display("FAIL async_reset: rd=%b wr=%b vld=%b rdy=%b rc=%0d wc=%0d addr=%0d required all 0",
                     mem_read, mem_write, rsp_valid, req_ready, rd_count, wr_count, mem_address);
            errors++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rd_count !== '0) begin
            $display("FAIL abandoned: vld=%b rc=%0d required 0 0", rsp_valid, rd_count);
            errors++;
        end
        send_req(1'b0, 9'd87, '0);
        wait_rsp(9'd87, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (rsp_rdata !== {16{32'h7FFF_FFFF}} || lat != 3) begin
            $display("FAIL read87_data: got %h lat=%0d required all 7FFFFFFF lat 3", rsp_rdata, lat);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd1) begin
            $display("FAIL read87_count: rd_count=%0d required 1", rd_count);
            errors++;
        end
        $display("async reset then read addr 87: rd_count=%0d", rd_count);
    endtask

    task automatic test_wrap();
        int lat, rc, wc, bad;
        logic [511:0] exp;
        for (int i = 0; i < 16; i++) exp[i*32 +: 32] = init_word((510 + i) % 512);
        send_req(1'b0, 9'd510, '0);
        wait_rsp(9'd510, 1'b0, '0, lat, rc, wc, bad);
        checks++;
        if (bad != 0 || rc != 2 || mem_address !== 9'd510) begin
            $display("FAIL wrap_addr: mem_address=%0d bad=%0d rd=%0d required 510 0 2", mem_address, bad, rc);
            errors++;
        end
        checks++;
        if (rsp_rdata !== exp) begin
            $display("FAIL wrap_data: got %h required %h", rsp_rdata, exp);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd2) begin
            $display("FAIL wrap_count: rd_count=%0d required 2", rd_count);
            errors++;
        end
        $display("read addr 510 (wrap): rd_count=%0d", rd_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_read_patterns();
        test_write_read();
        test_backpressure();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
